uart_bram_loader: RTL
=====================

Name: uart_bram_loader

Overview:
- Receive side of the board UART link: deserializes bytes from the host (8 data bits, parity, 1 stop bit) and writes them sequentially into the 8x2048 block RAM.
- Once the loader is armed, it fills addresses 0..DEPTH-1 and then reports completion.
- It drives BRAM port A (write only). Afterwards, the existing BRAM read/send path dumps the memory back for comparison.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line rate. CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, 5208 at defaults).
- DATA_WIDTH, 8, data bits per frame and BRAM word width.
- DEPTH, 2048, number of BRAM words to fill.
- ADDR_WIDTH, 11, BRAM address width. Requirement: 2^ADDR_WIDTH >= DEPTH.
- PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity.

Ports:
- sys_clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- uart_rxd  in  1  asynchronous serial input; idles high.
- load_enable  in  1  level input. A rising edge arms a load; deasserting it aborts the load.
- bram_we  out  1  one-cycle write strobe to BRAM port A.
- bram_addr  out  ADDR_WIDTH  BRAM write address.
- bram_din  out  DATA_WIDTH  BRAM write data.
- load_done  out  1  high once DEPTH words have been written.
- parity_err  out  1  sticky: at least one frame had bad parity.
- frame_err  out  1  sticky: at least one frame had its stop bit sampled low.
- byte_cnt  out  ADDR_WIDTH+1  count of words written in the current load.
- led  out  8  state indicator.

Behaviour:
Reset values:
- bram_we=0, bram_addr=0, bram_din=0.
- load_done=0, parity_err=0, frame_err=0, byte_cnt=0.
- led=8'b11000000.
- Both FSMs return to IDLE.
- The rxd synchronizer resets to 1. Any partial frame is discarded.

Input synchronizer:
- uart_rxd passes through a 2-flop synchronizer.
- A start is detected only on a 1->0 transition of the synchronized signal.

RX FSM states: R_IDLE, R_START, R_DATA, R_PARITY, R_STOP.
- R_IDLE: a falling edge loads the bit counter and moves to R_START.
- R_START: wait CLKS_PER_BIT/2 cycles, then sample. If the sample is 1 (glitch), return to R_IDLE. If 0, go to R_DATA.
- R_DATA: sample every CLKS_PER_BIT cycles, DATA_WIDTH samples, LSB first.
- R_PARITY: one sample, compared against XOR of the data bits, inverted when PARITY_ODD=1. This state is skipped when PARITY_EN=0.
- R_STOP: one sample, then unconditionally return to R_IDLE.
- Result: one-cycle rx_valid, asserted the cycle after the stop sample, together with per-frame pe/fe flags.
- A line held low (break) produces fe=1. No new frame starts until the line has returned high and then fallen again.

Writer FSM states: W_IDLE, W_ARMED, W_DONE.
- W_IDLE: led=8'b11000000. A load_enable rising edge moves to W_ARMED and clears bram_addr, byte_cnt, load_done, parity_err and frame_err.
- W_ARMED: led=8'b00110000.
  - On rx_valid with pe=0 and fe=0: in the next cycle, bram_we=1, bram_din=received byte, bram_addr=current address.
  - In the cycle after the strobe, bram_addr increments by 1 and byte_cnt increments by 1.
  - On rx_valid with pe=1: no write, no address advance; parity_err is set.
  - On rx_valid with fe=1: no write, no address advance; frame_err is set.
  - When the word at address DEPTH-1 is written: go to W_DONE, set load_done=1, and hold bram_addr at DEPTH-1 (no wrap).
- W_DONE: led=8'b00000011. Further bytes are ignored. load_done stays high until a new load_enable rising edge re-arms (directly to W_ARMED with all clears applied).

Boundary conditions:
- Bytes received in W_IDLE or W_DONE are discarded and never write the BRAM.
- load_enable deasserted while in W_ARMED aborts to W_IDLE. load_done stays 0, and words already written remain in the BRAM.
- A load_enable rising edge in the same cycle as rx_valid: the arm takes priority and the byte is discarded.
- The RX FSM runs regardless of the writer state. Reset is the only thing that interrupts a frame.
- Latency from stop-bit sample to bram_we is exactly 2 cycles. bram_we is never high for 2 consecutive cycles.

Test Plan:
- Bench overrides CLK_FREQ=1000000, BAUD=100000 (10 clks/bit), DEPTH=4, ADDR_WIDTH=2.
- Arm, then send 0xA5, 0x3C, 0xFF, 0x00 with correct even parity -> writes (0,A5), (1,3C), (2,FF), (3,00); each bram_we lasts 1 cycle, 2 cycles after the stop sample; load_done=1, byte_cnt=4, led=8'b00000011.
- Arm, send 0x55 with a wrong parity bit, then 0x55 correct -> first frame: no bram_we, parity_err=1; second frame written at addr 0.
- Send 0x12 with the stop bit low, then hold rxd low for 30 clocks -> frame_err=1, no write, no spurious frame until rxd rises and falls again.
- Glitch rxd low for 3 clocks while idle -> no frame, no strobe. Send 0x77 before arming -> no write.
- Arm, send 2 bytes, drop load_enable, raise it again, send 0x99 -> state IDLE then ARMED, byte_cnt restarts, 0x99 written at addr 0.
- Assert rst mid-data-bits -> all outputs return to reset values; the next complete frame is received correctly after re-arming.

Source files
------------

// File: rtl/uart_bram_loader.sv
// UART receiver (8 data bits, optional parity, 1 stop) feeding a sequential BRAM port-A writer.
// A rising edge on load_enable arms a fill of addresses 0..DEPTH-1; load_done flags completion.
module uart_bram_loader #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2048,
  parameter int ADDR_WIDTH = 11,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  uart_rxd,
  input  logic                  load_enable,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic                  load_done,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic [ADDR_WIDTH:0]   byte_cnt,
  output logic [7:0]            led
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W        = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]      BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]      HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [BIT_W-1:0]      BIT_ZERO  = {BIT_W{1'b0}};
  localparam logic [BIT_W-1:0]      BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0]      DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   BCNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   BCNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [7:0]            LED_IDLE  = 8'b1100_0000;
  localparam logic [7:0]            LED_ARMED = 8'b0011_0000;
  localparam logic [7:0]            LED_DONE  = 8'b0000_0011;

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP} rx_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ARMED, W_DONE} w_state_t;

  // Expected parity bit for a data word (even by default, inverted for odd)
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data);
    parity_bit = (^data) ^ (PARITY_ODD != 0);
  endfunction

  logic rxd_meta_r, rxd_sync_r, rxd_prev_r;
  logic fall_s;

  rx_state_t              rx_state_r, rx_state_s;
  logic [CNT_W-1:0]       clk_cnt_r, clk_cnt_s;
  logic [BIT_W-1:0]       bit_cnt_r, bit_cnt_s;
  logic [DATA_WIDTH-1:0]  shift_r, shift_s;
  logic                   frame_pe_r, frame_pe_s;
  logic                   rx_valid_r, rx_valid_s;
  logic [DATA_WIDTH-1:0]  rx_byte_r, rx_byte_s;
  logic                   rx_pe_r, rx_pe_s;
  logic                   rx_fe_r, rx_fe_s;

  w_state_t               w_state_r, w_state_s;
  logic                   we_r, we_s;
  logic [ADDR_WIDTH-1:0]  addr_r, addr_s;
  logic [DATA_WIDTH-1:0]  din_r, din_s;
  logic                   done_r, done_s;
  logic                   perr_r, perr_s;
  logic                   ferr_r, ferr_s;
  logic [ADDR_WIDTH:0]    cnt_r, cnt_s;
  logic                   adv_r, adv_s;
  logic                   le_prev_r;
  logic [7:0]             led_r, led_s;
  logic                   arm_s;

  // Two-flop synchronizer plus one history flop for falling-edge start detection
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rxd_meta_r <= 1'b1;
      rxd_sync_r <= 1'b1;
      rxd_prev_r <= 1'b1;
    end else begin
      rxd_meta_r <= uart_rxd;
      rxd_sync_r <= rxd_meta_r;
      rxd_prev_r <= rxd_sync_r;
    end
  end

  // A held-low break produces no edge, so a new frame needs the line to rise first
  assign fall_s = rxd_prev_r & ~rxd_sync_r;

  // Receiver state register
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rx_state_r <= R_IDLE;
      clk_cnt_r  <= CNT_ZERO;
      bit_cnt_r  <= BIT_ZERO;
      shift_r    <= DATA_ZERO;
      frame_pe_r <= 1'b0;
      rx_valid_r <= 1'b0;
      rx_byte_r  <= DATA_ZERO;
      rx_pe_r    <= 1'b0;
      rx_fe_r    <= 1'b0;
    end else begin
      rx_state_r <= rx_state_s;
      clk_cnt_r  <= clk_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      shift_r    <= shift_s;
      frame_pe_r <= frame_pe_s;
      rx_valid_r <= rx_valid_s;
      rx_byte_r  <= rx_byte_s;
      rx_pe_r    <= rx_pe_s;
      rx_fe_r    <= rx_fe_s;
    end
  end

  // Receiver next-state: mid-bit sampling, result published one cycle after the stop sample
  always_comb begin
    rx_state_s = rx_state_r;
    clk_cnt_s  = clk_cnt_r;
    bit_cnt_s  = bit_cnt_r;
    shift_s    = shift_r;
    frame_pe_s = frame_pe_r;
    rx_valid_s = 1'b0;
    rx_byte_s  = rx_byte_r;
    rx_pe_s    = rx_pe_r;
    rx_fe_s    = rx_fe_r;
    case (rx_state_r)
      R_IDLE: begin
        clk_cnt_s = CNT_ZERO;
        if (fall_s) begin
          rx_state_s = R_START;
          bit_cnt_s  = BIT_ZERO;
          frame_pe_s = 1'b0;
        end else begin
          rx_state_s = R_IDLE;
        end
      end
      R_START: begin
        if (clk_cnt_r == HALF_LAST) begin
          clk_cnt_s = CNT_ZERO;
          if (rxd_sync_r) begin
            rx_state_s = R_IDLE;
          end else begin
            rx_state_s = R_DATA;
          end
        end else begin
          clk_cnt_s = clk_cnt_r + CNT_ONE;
        end
      end
      R_DATA: begin
        if (clk_cnt_r == BIT_LAST) begin
          clk_cnt_s = CNT_ZERO;
          shift_s   = {rxd_sync_r, shift_r[DATA_WIDTH-1:1]};
          if (bit_cnt_r == DATA_LAST) begin
            if (PARITY_EN != 0) begin
              rx_state_s = R_PARITY;
            end else begin
              rx_state_s = R_STOP;
            end
          end else begin
            bit_cnt_s = bit_cnt_r + BIT_ONE;
          end
        end else begin
          clk_cnt_s = clk_cnt_r + CNT_ONE;
        end
      end
      R_PARITY: begin
        if (clk_cnt_r == BIT_LAST) begin
          clk_cnt_s  = CNT_ZERO;
          frame_pe_s = (rxd_sync_r != parity_bit(shift_r));
          rx_state_s = R_STOP;
        end else begin
          clk_cnt_s = clk_cnt_r + CNT_ONE;
        end
      end
      R_STOP: begin
        if (clk_cnt_r == BIT_LAST) begin
          clk_cnt_s  = CNT_ZERO;
          rx_valid_s = 1'b1;
          rx_byte_s  = shift_r;
          rx_pe_s    = frame_pe_r;
          rx_fe_s    = ~rxd_sync_r;
          rx_state_s = R_IDLE;
        end else begin
          clk_cnt_s = clk_cnt_r + CNT_ONE;
        end
      end
      default: begin
        rx_state_s = R_IDLE;
        clk_cnt_s  = CNT_ZERO;
      end
    endcase
  end

  assign arm_s = load_enable & ~le_prev_r;

  // Writer state register and all registered outputs
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      w_state_r <= W_IDLE;
      we_r      <= 1'b0;
      addr_r    <= ADDR_ZERO;
      din_r     <= DATA_ZERO;
      done_r    <= 1'b0;
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
      cnt_r     <= BCNT_ZERO;
      adv_r     <= 1'b0;
      le_prev_r <= 1'b0;
      led_r     <= LED_IDLE;
    end else begin
      w_state_r <= w_state_s;
      we_r      <= we_s;
      addr_r    <= addr_s;
      din_r     <= din_s;
      done_r    <= done_s;
      perr_r    <= perr_s;
      ferr_r    <= ferr_s;
      cnt_r     <= cnt_s;
      adv_r     <= adv_s;
      le_prev_r <= load_enable;
      led_r     <= led_s;
    end
  end

  // Writer next-state: arm beats everything, address advances the cycle after each strobe
  always_comb begin
    w_state_s = w_state_r;
    we_s      = 1'b0;
    addr_s    = addr_r;
    din_s     = din_r;
    done_s    = done_r;
    perr_s    = perr_r;
    ferr_s    = ferr_r;
    cnt_s     = cnt_r;
    adv_s     = 1'b0;
    if (arm_s) begin
      w_state_s = W_ARMED;
      addr_s    = ADDR_ZERO;
      cnt_s     = BCNT_ZERO;
      done_s    = 1'b0;
      perr_s    = 1'b0;
      ferr_s    = 1'b0;
    end else begin
      case (w_state_r)
        W_ARMED: begin
          if (!load_enable) begin
            w_state_s = W_IDLE;
          end else begin
            if (adv_r) begin
              cnt_s = cnt_r + BCNT_ONE;
              if (addr_r == ADDR_LAST) begin
                w_state_s = W_DONE;
                done_s    = 1'b1;
              end else begin
                addr_s = addr_r + ADDR_ONE;
              end
            end else begin
              cnt_s = cnt_r;
            end
            if (rx_valid_r) begin
              if (rx_pe_r || rx_fe_r) begin
                perr_s = perr_r | rx_pe_r;
                ferr_s = ferr_r | rx_fe_r;
              end else begin
                we_s  = 1'b1;
                din_s = rx_byte_r;
                adv_s = 1'b1;
              end
            end else begin
              we_s = 1'b0;
            end
          end
        end
        W_IDLE:  w_state_s = W_IDLE;
        W_DONE:  w_state_s = W_DONE;
        default: w_state_s = W_IDLE;
      endcase
    end
  end

  // LED pattern follows the writer state it is about to enter
  always_comb begin
    case (w_state_s)
      W_IDLE:  led_s = LED_IDLE;
      W_ARMED: led_s = LED_ARMED;
      W_DONE:  led_s = LED_DONE;
      default: led_s = LED_IDLE;
    endcase
  end

  assign bram_we    = we_r;
  assign bram_addr  = addr_r;
  assign bram_din   = din_r;
  assign load_done  = done_r;
  assign parity_err = perr_r;
  assign frame_err  = ferr_r;
  assign byte_cnt   = cnt_r;
  assign led        = led_r;

endmodule
